// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Central stall/flush sequencer for the 5-stage MIPS pipeline. Every cycle it
// decides whether PC, IF/ID, ID/EX and EX/MEM advance, hold or take a bubble,
// and whether MEM/WB captures a killed (no-writeback) entry.
//
// Events handled, highest priority first:
//   1. Data-memory wait (variable latency handshake, bounded by MEM_TIMEOUT)
//   2. Taken-branch flush of IF/ID and ID/EX
//   3. Load-use hazard bubble
//
// Parameters:
//   MEM_TIMEOUT  max frozen cycles of a data access before it is aborted (>=2)
//   CNT_W        width of the saturating performance counters
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_usesRt           ID instruction actually reads rt
//   ex_memRead          EX instruction is a load
//   ex_writeReg         destination register of the EX instruction
//   ex_branchTaken      branch in EX resolved taken
//   mem_req             MEM instruction performs a load/store
//   dmem_ready          data memory completes the access this cycle
//   dmem_valid          request to data memory
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register load enables
//   ifid_flush, idex_flush              load NOP / bubble
//   memwb_kill          MEM/WB captures regWrite=0
//   mem_err             sticky data access timeout flag
//   stall_cycles        saturating count of cycles with pc_en=0
//   flush_count         saturating count of branch flushes
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_usesRt,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_writeReg,
    input  logic             ex_branchTaken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_kill,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Wait counter only needs to reach MEM_TIMEOUT-1.
    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state_q,        state_d;
    logic [WC_W-1:0]  wait_cnt_q,     wait_cnt_d;
    logic             mem_err_q,      mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q,  flush_count_d;

    logic load_use;
    logic mem_stall;
    logic mem_abort;
    logic branch_flush;

    // Pipeline-control decisions before the reset override.
    logic run_pc_en;
    logic run_ifid_en;
    logic run_ifid_flush;
    logic run_idex_en;
    logic run_idex_flush;
    logic run_exmem_en;
    logic run_memwb_kill;

    // Hazard and memory-event detection.
    always_comb begin
        load_use = ex_memRead && (ex_writeReg != 5'd0) &&
                   ((ex_writeReg == id_rs) || (id_usesRt && (ex_writeReg == id_rt)));

        // A request that is not ready freezes the pipe, except on the last
        // allowed wait cycle, where the access is abandoned instead.
        mem_stall = 1'b0;
        mem_abort = 1'b0;
        if (state_q == RUN) begin
            mem_stall = mem_req && !dmem_ready;
        end else begin
            if (!dmem_ready) begin
                if (wait_cnt_q == WC_LAST) begin
                    mem_abort = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
        end

        branch_flush = !mem_stall && ex_branchTaken;
    end

    // Enable/flush generation. A branch still sitting in EX while memory was
    // stalling is naturally re-applied on the release cycle because the
    // frozen EX register keeps presenting it.
    always_comb begin
        run_pc_en      = 1'b1;
        run_ifid_en    = 1'b1;
        run_ifid_flush = 1'b0;
        run_idex_en    = 1'b1;
        run_idex_flush = 1'b0;
        run_exmem_en   = 1'b1;
        run_memwb_kill = 1'b0;

        if (mem_stall) begin
            run_pc_en      = 1'b0;
            run_ifid_en    = 1'b0;
            run_idex_en    = 1'b0;
            run_exmem_en   = 1'b0;
            run_memwb_kill = 1'b1;
        end else begin
            // The aborted access must not write back, but the pipe moves on.
            if (mem_abort) begin
                run_memwb_kill = 1'b1;
            end
            if (branch_flush) begin
                run_ifid_flush = 1'b1;
                run_idex_flush = 1'b1;
            end else if (load_use) begin
                run_pc_en      = 1'b0;
                run_ifid_en    = 1'b0;
                run_idex_flush = 1'b1;
            end
        end
    end

    // While reset is asserted the pipeline is held with a killed writeback
    // and no memory request, independent of the clock.
    always_comb begin
        if (!rst_n) begin
            dmem_valid = 1'b0;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_en    = 1'b0;
            idex_flush = 1'b0;
            exmem_en   = 1'b0;
            memwb_kill = 1'b1;
        end else begin
            dmem_valid = mem_req;
            pc_en      = run_pc_en;
            ifid_en    = run_ifid_en;
            ifid_flush = run_ifid_flush;
            idex_en    = run_idex_en;
            idex_flush = run_idex_flush;
            exmem_en   = run_exmem_en;
            memwb_kill = run_memwb_kill;
        end
    end

    // Next-state, wait counter, error flag and counter updates.
    always_comb begin
        state_d        = mem_stall ? MEM_WAIT : RUN;
        wait_cnt_d     = '0;
        mem_err_d      = mem_err_q | mem_abort;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        if ((state_q == MEM_WAIT) && mem_stall) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
        end

        if (!run_pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end

        if (branch_flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Directed bench for pipe_ctrl with MEM_TIMEOUT=4 and CNT_W=4 so both the
// timeout path and counter saturation are reachable in a few cycles.
// Control outputs are compared as one packed vector:
//   {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_kill, dmem_valid}
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Expected control vectors.
    localparam logic [7:0] CTL_RESET   = 8'b0000_0010;
    localparam logic [7:0] CTL_IDLE    = 8'b1101_0100;
    localparam logic [7:0] CTL_ZWAIT   = 8'b1101_0101;
    localparam logic [7:0] CTL_LDUSE   = 8'b0001_1100;
    localparam logic [7:0] CTL_BRANCH  = 8'b1111_1100;
    localparam logic [7:0] CTL_FROZEN  = 8'b0000_0011;
    localparam logic [7:0] CTL_REL_BR  = 8'b1111_1101;
    localparam logic [7:0] CTL_ABORT   = 8'b1101_0111;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_usesRt;
    logic             ex_memRead;
    logic [4:0]       ex_writeReg;
    logic             ex_branchTaken;
    logic             mem_req;
    logic             dmem_ready;
    logic             dmem_valid;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_kill;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    logic [7:0] ctl;
    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_kill, dmem_valid};

    int errCount   = 0;
    int checkCount = 0;

    pipe_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_usesRt     (id_usesRt),
        .ex_memRead    (ex_memRead),
        .ex_writeReg   (ex_writeReg),
        .ex_branchTaken(ex_branchTaken),
        .mem_req       (mem_req),
        .dmem_ready    (dmem_ready),
        .dmem_valid    (dmem_valid),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_en       (idex_en),
        .idex_flush    (idex_flush),
        .exmem_en      (exmem_en),
        .memwb_kill    (memwb_kill),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive all inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic memReq, input logic ready, input logic branch,
                                 input logic memRead, input logic [4:0] wr,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic usesRt);
        mem_req        = memReq;
        dmem_ready     = ready;
        ex_branchTaken = branch;
        ex_memRead     = memRead;
        ex_writeReg    = wr;
        id_rs          = rs;
        id_rt          = rt;
        id_usesRt      = usesRt;
        #1;
    endtask

    // Advance one clock, landing just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Reset: request suppressed, pipe held with killed writeback.
        checkOutput("reset_ctl", 32'(ctl), 32'(CTL_RESET));
        checkOutput("reset_stall", 32'(stall_cycles), 32'd0);
        checkOutput("reset_flush", 32'(flush_count), 32'd0);
        checkOutput("reset_err", 32'(mem_err), 32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("idle_ctl", 32'(ctl), 32'(CTL_IDLE));

        // Zero-wait access: no stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("zwait_ctl", 32'(ctl), 32'(CTL_ZWAIT));
        tick();
        checkOutput("zwait_ctl2", 32'(ctl), 32'(CTL_ZWAIT));
        checkOutput("zwait_stall", 32'(stall_cycles), 32'd0);

        // Load-use on rs.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        checkOutput("lduse_rs_ctl", 32'(ctl), 32'(CTL_LDUSE));
        tick();
        checkOutput("lduse_rs_stall", 32'(stall_cycles), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd0, 1'b0);
        checkOutput("lduse_clear_ctl", 32'(ctl), 32'(CTL_IDLE));

        // Load to $zero never stalls.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("lduse_r0_ctl", 32'(ctl), 32'(CTL_IDLE));
        tick();
        checkOutput("lduse_r0_stall", 32'(stall_cycles), 32'd1);

        // Load-use on rt only counts when rt is actually read.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1);
        checkOutput("lduse_rt_ctl", 32'(ctl), 32'(CTL_LDUSE));
        tick();
        checkOutput("lduse_rt_stall", 32'(stall_cycles), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0);
        checkOutput("lduse_rtunused_ctl", 32'(ctl), 32'(CTL_IDLE));
        tick();
        checkOutput("lduse_rtunused_stall", 32'(stall_cycles), 32'd2);

        // Branch wins over a simultaneous load-use hazard.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        checkOutput("br_ctl", 32'(ctl), 32'(CTL_BRANCH));
        tick();
        checkOutput("br_flush", 32'(flush_count), 32'd1);
        checkOutput("br_stall", 32'(stall_cycles), 32'd2);

        // Memory wait with 3 frozen cycles; a branch held in EX is ignored
        // while frozen and applied on release.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mw_frozen0", 32'(ctl), 32'(CTL_FROZEN));
        tick();
        checkOutput("mw_frozen1", 32'(ctl), 32'(CTL_FROZEN));
        tick();
        checkOutput("mw_frozen2", 32'(ctl), 32'(CTL_FROZEN));
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mw_release", 32'(ctl), 32'(CTL_REL_BR));
        tick();
        checkOutput("mw_stall", 32'(stall_cycles), 32'd5);
        checkOutput("mw_flush", 32'(flush_count), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("mw_back_run", 32'(ctl), 32'(CTL_IDLE));

        // Timeout: 4 frozen cycles, one abort cycle, then sticky mem_err.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("to_frozen0", 32'(ctl), 32'(CTL_FROZEN));
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            tick();
            checkOutput($sformatf("to_frozen%0d", i), 32'(ctl), 32'(CTL_FROZEN));
        end
        tick();
        checkOutput("to_abort", 32'(ctl), 32'(CTL_ABORT));
        checkOutput("to_err_before", 32'(mem_err), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("to_err_set", 32'(mem_err), 32'd1);
        checkOutput("to_run_ctl", 32'(ctl), 32'(CTL_IDLE));
        checkOutput("to_stall", 32'(stall_cycles), 32'd9);
        tick();
        checkOutput("to_err_sticky", 32'(mem_err), 32'd1);

        // Reset in the middle of a wait drops the request immediately.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        checkOutput("rst_pre_frozen", 32'(ctl), 32'(CTL_FROZEN));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ctl", 32'(ctl), 32'(CTL_RESET));
        checkOutput("rst_mid_stall", 32'(stall_cycles), 32'd0);
        checkOutput("rst_mid_flush", 32'(flush_count), 32'd0);
        checkOutput("rst_mid_err", 32'(mem_err), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_rel_frozen", 32'(ctl), 32'(CTL_FROZEN));

        // Restart from RUN: ready on the timeout cycle completes normally.
        for (int i = 1; i < MEM_TIMEOUT; i++) begin
            tick();
            checkOutput($sformatf("rdy_frozen%0d", i), 32'(ctl), 32'(CTL_FROZEN));
        end
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("rdy_release", 32'(ctl), 32'(CTL_ZWAIT));
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("rdy_err_clear", 32'(mem_err), 32'd0);
        checkOutput("rdy_stall", 32'(stall_cycles), 32'd4);

        // Saturation: 20 more stall cycles and 20 flushes clamp at 15.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
            tick();
        end
        checkOutput("sat_stall", 32'(stall_cycles), 32'd15);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            tick();
        end
        checkOutput("sat_flush", 32'(flush_count), 32'd15);
        checkOutput("sat_stall_hold", 32'(stall_cycles), 32'd15);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
